// File: rtl/lc3_controller_if.sv
// lc3_controller_if: bundle of the controller's status inputs and its
// stage-enable / forwarding / memory-state outputs. The master side is the
// surrounding pipeline (control_in bus plus datapath). The slave side is
// lc3_controller.
interface lc3_controller_if;
    logic        complete_data;
    logic        complete_instr;
    logic [15:0] IR;
    logic [2:0]  psr;
    logic [15:0] IR_Exec;
    logic [15:0] IMem_dout;
    logic [2:0]  NZP;

    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        bypass_mem_1;
    logic        bypass_mem_2;
    logic        br_taken;
    logic [1:0]  mem_state;

    modport master (
        output complete_data, complete_instr, IR, psr, IR_Exec, IMem_dout, NZP,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, bypass_alu_1, bypass_alu_2, bypass_mem_1,
               bypass_mem_2, br_taken, mem_state
    );

    modport slave (
        input  complete_data, complete_instr, IR, psr, IR_Exec, IMem_dout, NZP,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, bypass_alu_1, bypass_alu_2, bypass_mem_1,
               bypass_mem_2, br_taken, mem_state
    );
endinterface

// File: rtl/lc3_controller.sv
// lc3_controller: LC3 pipeline controller. It handles fill after reset,
// memory-access stalls (LD/LDR/LDI/ST/STR/STI), the fetch hold for BR/JMP,
// and operand forwarding selects for Execute.
// Optional macro LC3_CTRL_BYPASS_EN builds the forwarding logic. Without the
// macro, all bypass outputs are tied to 0.
//
// State: r_vld[0] is the "running" bit that is set after reset.
// r_vld[1..3] are the D/E/W valid bits. r_brt[1..3] tags where a fetched
// control-transfer instruction sits in the chain. r_hold keeps fetch off
// until that instruction has passed Execute, which costs 3 fetch slots.
// While the memory FSM is busy, the whole chain is frozen.
module lc3_controller (
    input  logic               clock,
    input  logic               reset,
    lc3_controller_if.slave    bus
);
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic [1:0] {
        MS_READ  = 2'd0,
        MS_IND   = 2'd1,
        MS_WRITE = 2'd2,
        MS_IDLE  = 2'd3
    } mem_state_t;

    logic [3:0] r_vld;
    logic [3:1] r_brt;
    logic       r_hold;
    logic       r_ind_store;
    mem_state_t r_mem;

    logic [3:0] w_op_e;
    logic [3:0] w_op_f;
    logic       w_stall;
    logic       w_fetch;
    logic       w_exe;
    logic       w_mem_op_e;
    logic       w_issue;
    logic       w_br_f;
    logic       w_unused;

    assign w_op_e     = bus.IR_Exec[15:12];
    assign w_op_f     = bus.IMem_dout[15:12];
    assign w_stall    = (r_mem != MS_IDLE);
    assign w_fetch    = r_vld[0] & ~r_hold & ~w_stall & bus.complete_instr;
    assign w_exe      = r_vld[2] & ~w_stall;
    assign w_mem_op_e = (w_op_e == OP_LD)  | (w_op_e == OP_LDR) | (w_op_e == OP_LDI) |
                        (w_op_e == OP_ST)  | (w_op_e == OP_STR) | (w_op_e == OP_STI);
    assign w_issue    = w_exe & w_mem_op_e;
    assign w_br_f     = w_fetch & ((w_op_f == OP_BR) | (w_op_f == OP_JMP));
    assign w_unused   = ^{bus.IMem_dout[11:0], bus.IR_Exec[8:0]};

    // Pipeline valid chain, branch hold and memory-access FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld       <= '0;
            r_brt       <= '0;
            r_hold      <= 1'b0;
            r_ind_store <= 1'b0;
            r_mem       <= MS_IDLE;
        end else begin
            r_vld[0] <= 1'b1;
            case (r_mem)
                MS_IDLE: begin
                    if (w_issue) begin
                        case (w_op_e)
                            OP_LD, OP_LDR: r_mem <= MS_READ;
                            OP_ST, OP_STR: r_mem <= MS_WRITE;
                            default: begin
                                r_mem       <= MS_IND;
                                r_ind_store <= (w_op_e == OP_STI);
                            end
                        endcase
                    end
                end
                MS_IND:  if (bus.complete_data) r_mem <= r_ind_store ? MS_WRITE : MS_READ;
                default: if (bus.complete_data) r_mem <= MS_IDLE;
            endcase
            // Chain advances only while memory is idle. A memory op leaving
            // Execute never reaches W because the FSM owns its writeback.
            if (!w_stall) begin
                r_vld[1] <= w_fetch;
                r_vld[2] <= r_vld[1];
                r_vld[3] <= r_vld[2] & ~w_issue;
                r_brt[1] <= w_br_f;
                r_brt[2] <= r_brt[1];
                r_brt[3] <= r_brt[2];
                if (w_br_f)
                    r_hold <= 1'b1;
                else if (r_brt[3])
                    r_hold <= 1'b0;
            end
        end
    end

    // Stage enables are decoded straight from the state flops. Writeback
    // during a stall is the final cycle of a read.
    always_comb begin
        bus.enable_fetch     = w_fetch;
        bus.enable_updatePC  = w_fetch;
        bus.enable_decode    = r_vld[1] & ~w_stall;
        bus.enable_execute   = w_exe;
        bus.enable_writeback = w_stall ? ((r_mem == MS_READ) & bus.complete_data) : r_vld[3];
        bus.mem_state        = r_mem;
    end

    // Control transfer is resolved when the instruction is valid in Execute
    always_comb begin
        bus.br_taken = w_exe & ((w_op_e == OP_JMP) |
                                ((w_op_e == OP_BR) & (|(bus.NZP & bus.psr))));
    end

`ifdef LC3_CTRL_BYPASS_EN
    logic [3:0] w_op_d;
    logic [2:0] w_dr_e;
    logic       w_alu_e;
    logic       w_ld_e;
    logic       w_src1;
    logic       w_src2;
    logic       w_unused_byp;

    assign w_op_d       = bus.IR[15:12];
    assign w_dr_e       = bus.IR_Exec[11:9];
    assign w_alu_e      = (w_op_e == OP_ADD) | (w_op_e == OP_AND) | (w_op_e == OP_NOT);
    assign w_ld_e       = (w_op_e == OP_LD) | (w_op_e == OP_LDR) | (w_op_e == OP_LDI);
    assign w_src1       = ((w_op_d == OP_ADD) | (w_op_d == OP_AND) | (w_op_d == OP_NOT) |
                           (w_op_d == OP_LDR) | (w_op_d == OP_STR) | (w_op_d == OP_JMP)) &
                          (bus.IR[8:6] == w_dr_e);
    assign w_src2       = ((w_op_d == OP_ADD) | (w_op_d == OP_AND)) & ~bus.IR[5] &
                          (bus.IR[2:0] == w_dr_e);
    assign w_unused_byp = ^bus.IR[4:3];

    // Forward the Execute result into the operand that reads its DR
    always_comb begin
        bus.bypass_alu_1 = w_exe & w_alu_e & w_src1;
        bus.bypass_alu_2 = w_exe & w_alu_e & w_src2;
        bus.bypass_mem_1 = w_exe & w_ld_e  & w_src1;
        bus.bypass_mem_2 = w_exe & w_ld_e  & w_src2;
    end
`else
    logic w_unused_byp;
    assign w_unused_byp = ^{bus.IR, bus.IR_Exec[11:9]};

    // No hazard logic: software schedules NOPs between dependent ops
    always_comb begin
        bus.bypass_alu_1 = 1'b0;
        bus.bypass_alu_2 = 1'b0;
        bus.bypass_mem_1 = 1'b0;
        bus.bypass_mem_2 = 1'b0;
    end
`endif
endmodule
